imem_boot_controller: RTL

Sequences the byte-addressed, big-endian instruction memory of the single-cycle MIPS-32 core. After reset it holds the core in stall while a byte stream from an external loader (UART/JTAG bridge) is written into consecutive memory locations, then switches to RUN and serves combinational 32-bit fetches at the PC. It owns the instruction storage, the load address counter, the BOOT/RUN state machine, and the fetch fault flags.

---
 rtl/imem_boot_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/imem_boot_controller.sv
// imem_boot_controller: byte-addressed, big-endian instruction memory for the
// single-cycle MIPS-32 core with a BOOT/RUN sequencer.
// BOOT: the core is stalled while a loader streams bytes into consecutive addresses.
// RUN: the core fetches 32-bit words combinationally at the PC.
// Optional feature macro: IMEM_RELOAD_EN adds reload_req, which re-enters BOOT from RUN.
module imem_boot_controller #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [31:0]       PC_Read_address,
  output logic [31:0]       Instruction_Out,
  output logic              cpu_stall,
  output logic              fetch_fault,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf
`ifdef IMEM_RELOAD_EN
  ,
  input  logic              reload_req
`endif
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Index of the final byte location; accepting there without ld_last ends the load.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  // Highest byte address that still holds a complete word.
  localparam logic [31:0]     MAX_PC   = 32'(DEPTH - 4);

  logic [7:0]      mem_r [DEPTH];
  state_t          state_r;
  logic [ADDR_W:0] load_count_r;
  logic            load_ovf_r;
  logic            ld_ready_r;
  logic            cpu_stall_r;
  logic            accept_s;
  logic            reload_s;
  logic [31:0]     instr_s;
  logic            fault_s;
  logic [ADDR_W-1:0] word_base_s;

  assign accept_s    = ld_valid & ld_ready_r;
`ifdef IMEM_RELOAD_EN
  assign reload_s    = reload_req;
`else
  assign reload_s    = 1'b0;
`endif
  assign word_base_s = {PC_Read_address[ADDR_W-1:2], 2'b00};

  // BOOT/RUN sequencer with load counter, sticky overflow flag and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_BOOT;
      load_count_r <= '0;
      load_ovf_r   <= 1'b0;
      ld_ready_r   <= 1'b1;
      cpu_stall_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_BOOT: begin
          if (accept_s) begin
            load_count_r <= load_count_r + (ADDR_W+1)'(1);
            if (ld_last) begin
              state_r     <= ST_RUN;
              ld_ready_r  <= 1'b0;
              cpu_stall_r <= 1'b0;
            end else if (load_count_r == LAST_IDX) begin
              // Memory is full: treat this byte as an implicit last and flag it.
              load_ovf_r  <= 1'b1;
              state_r     <= ST_RUN;
              ld_ready_r  <= 1'b0;
              cpu_stall_r <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (reload_s) begin
            state_r      <= ST_BOOT;
            load_count_r <= '0;
            load_ovf_r   <= 1'b0;
            ld_ready_r   <= 1'b1;
            cpu_stall_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_BOOT;
          ld_ready_r  <= 1'b1;
          cpu_stall_r <= 1'b1;
        end
      endcase
    end
  end

  // Instruction storage write port; contents survive reset and a reset cycle never writes.
  always_ff @(posedge clk) begin
    if (!reset && accept_s) begin
      mem_r[load_count_r[ADDR_W-1:0]] <= ld_byte;
    end
  end

  // Combinational big-endian fetch with NOP substitution on misaligned or out-of-range PC.
  always_comb begin
    instr_s = 32'h0000_0000;
    fault_s = 1'b0;
    if (state_r == ST_RUN) begin
      if ((PC_Read_address[1:0] != 2'b00) || (PC_Read_address > MAX_PC)) begin
        instr_s = 32'h0000_0000;
        fault_s = 1'b1;
      end else begin
        instr_s = {mem_r[word_base_s],
                   mem_r[word_base_s | ADDR_W'(1)],
                   mem_r[word_base_s | ADDR_W'(2)],
                   mem_r[word_base_s | ADDR_W'(3)]};
        fault_s = 1'b0;
      end
    end else begin
      instr_s = 32'h0000_0000;
      fault_s = 1'b0;
    end
  end

  assign Instruction_Out = instr_s;
  assign fetch_fault     = fault_s;
  assign ld_ready        = ld_ready_r;
  assign cpu_stall       = cpu_stall_r;
  assign load_count      = load_count_r;
  assign load_ovf        = load_ovf_r;

endmodule
